// File: rtl/tlc_pkg.sv
// Shared state encoding, light codes and output decode for the actuated traffic light controller.
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_EW_GREEN  = 3'd2,
        ST_EW_YELLOW = 3'd3,
        ST_ALLRED    = 3'd4,
        ST_PED_WALK  = 3'd5,
        ST_FLASH     = 3'd6
    } tlc_state_e;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } tlc_dir_e;

    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } tlc_lights_t;

    // Moore decode of the lamp pattern for a state
    function automatic tlc_lights_t decode_lights(tlc_state_e st, logic flash_on);
        tlc_lights_t l;
        l = '{ns: LIGHT_R, ew: LIGHT_R, walk: 1'b0};
        case (st)
            ST_NS_GREEN:  l.ns = LIGHT_G;
            ST_NS_YELLOW: l.ns = LIGHT_Y;
            ST_EW_GREEN:  l.ew = LIGHT_G;
            ST_EW_YELLOW: l.ew = LIGHT_Y;
            ST_PED_WALK:  l.walk = 1'b1;
            ST_FLASH: begin
                l.ns = flash_on ? LIGHT_Y : LIGHT_OFF;
                l.ew = flash_on ? LIGHT_R : LIGHT_OFF;
            end
            default: l = '{ns: LIGHT_R, ew: LIGHT_R, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Saturating tick counter measuring time spent in the current phase.
module tlc_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en_tick,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] min_cnt,
    output logic             at_limit,
    output logic             at_or_past
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en_tick && (count < limit)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit   = (count == limit);
    assign at_or_past = (count >= min_cnt);

endmodule

// File: rtl/tlc_actuated_ctrl.sv
// Sensor-actuated two-road traffic light controller with pedestrian all-red walk and night flash.
module tlc_actuated_ctrl
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_GREEN     = 20,
    parameter int unsigned T_GREEN_MIN = 8,
    parameter int unsigned T_YELLOW    = 4,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned T_PED       = 10,
    parameter int unsigned FLASH_HALF  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_tick,
    input  logic       car_ew,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] light_north_south,
    output logic [2:0] light_east_west,
    output logic       ped_walk
);

    tlc_state_e       state, state_n;
    tlc_dir_e         next_dir, dir_n;
    logic             ped_pending, pend_n;
    logic             flash_on, flash_n;
    logic             toggle, timer_clr;
    logic             at_limit, at_min;
    logic [CNT_W-1:0] limit;
    tlc_lights_t      lights_q;

    // Per-phase terminal count (tick index on which the phase may end)
    always_comb begin
        limit = '0;
        case (state)
            ST_NS_GREEN:  limit = CNT_W'(T_GREEN_MIN - 1);
            ST_NS_YELLOW: limit = CNT_W'(T_YELLOW - 1);
            ST_EW_GREEN:  limit = CNT_W'(T_GREEN - 1);
            ST_EW_YELLOW: limit = CNT_W'(T_YELLOW - 1);
            ST_ALLRED:    limit = CNT_W'(T_ALLRED - 1);
            ST_PED_WALK:  limit = CNT_W'(T_PED - 1);
            ST_FLASH:     limit = CNT_W'(FLASH_HALF - 1);
            default:      limit = '0;
        endcase
    end

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (timer_clr),
        .en_tick    (en_tick),
        .limit      (limit),
        .min_cnt    (CNT_W'(T_GREEN_MIN - 1)),
        .at_limit   (at_limit),
        .at_or_past (at_min)
    );

    always_comb begin
        state_n = state;
        dir_n   = next_dir;
        flash_n = flash_on;
        toggle  = 1'b0;
        if (en_tick) begin
            case (state)
                ST_NS_GREEN: begin
                    if (at_limit && (car_ew || ped_pending)) state_n = ST_NS_YELLOW;
                end
                ST_NS_YELLOW: begin
                    if (at_limit) begin
                        state_n = ped_pending ? ST_PED_WALK : ST_ALLRED;
                        dir_n   = DIR_EW;
                    end
                end
                ST_EW_GREEN: begin
                    if (at_limit || (at_min && !car_ew)) state_n = ST_EW_YELLOW;
                end
                ST_EW_YELLOW: begin
                    if (at_limit) begin
                        state_n = ped_pending ? ST_PED_WALK : ST_ALLRED;
                        dir_n   = DIR_NS;
                    end
                end
                ST_ALLRED, ST_PED_WALK: begin
                    if (at_limit) begin
                        if (night_mode) begin
                            state_n = ST_FLASH;
                            flash_n = 1'b1;
                        end else begin
                            state_n = (next_dir == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;
                        end
                    end
                end
                ST_FLASH: begin
                    if (!night_mode) begin
                        state_n = ST_ALLRED;
                        dir_n   = DIR_NS;
                    end else if (at_limit) begin
                        flash_n = ~flash_on;
                        toggle  = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_ALLRED;
                    dir_n   = DIR_NS;
                end
            endcase
        end

        // A new request in the same cycle as service is kept for the next all-red
        pend_n = ped_pending;
        if ((state_n != state) && ((state_n == ST_PED_WALK) || (state_n == ST_FLASH))) pend_n = 1'b0;
        if (ped_req && (state != ST_FLASH)) pend_n = 1'b1;

        timer_clr = toggle || (state_n != state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ALLRED;
            next_dir    <= DIR_NS;
            ped_pending <= 1'b0;
            flash_on    <= 1'b1;
            lights_q    <= '{ns: LIGHT_R, ew: LIGHT_R, walk: 1'b0};
        end else begin
            state       <= state_n;
            next_dir    <= dir_n;
            ped_pending <= pend_n;
            flash_on    <= flash_n;
            lights_q    <= decode_lights(state_n, flash_n);
        end
    end

    assign light_north_south = lights_q.ns;
    assign light_east_west   = lights_q.ew;
    assign ped_walk          = lights_q.walk;

endmodule

// File: tb/tb_tlc_actuated_ctrl.sv
// Bench for tlc_actuated_ctrl: phase-level reference model plus hand-computed lamp sequences.
module tb_tlc_actuated_ctrl;

    localparam int TG   = 6;
    localparam int TMIN = 3;
    localparam int TY   = 2;
    localparam int TAR  = 1;
    localparam int TPED = 4;
    localparam int FH   = 2;

    localparam int P_NSG = 0, P_NSY = 1, P_EWG = 2, P_EWY = 3, P_AR = 4, P_PED = 5, P_FL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en_tick = 1'b1;
    logic       car_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] ns, ew;
    logic       walk;

    int total = 0;
    int bad   = 0;

    // Reference model state: phase, ticks elapsed since phase entry (never cleared mid-phase)
    int m_ph = P_AR;
    int m_el = 0;
    bit m_dir_ns = 1'b1;
    bit m_pend = 1'b0;

    logic [2:0] s3_ns [1:16] = '{3'b001,3'b001,3'b001,3'b010,3'b010,3'b100,3'b100,3'b100,
                                 3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b001};
    logic [2:0] s3_ew [1:16] = '{3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b001,3'b001,
                                 3'b001,3'b001,3'b001,3'b001,3'b010,3'b010,3'b100,3'b100};
    logic [2:0] s4_ns [1:22] = '{3'b001,3'b010,3'b010,3'b100,3'b100,3'b100,3'b100,3'b100,
                                 3'b100,3'b100,3'b100,3'b100,3'b100,3'b010,3'b010,3'b000,
                                 3'b000,3'b010,3'b010,3'b000,3'b100,3'b001};
    logic [2:0] s4_ew [1:22] = '{3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b001,
                                 3'b001,3'b001,3'b010,3'b010,3'b100,3'b100,3'b100,3'b000,
                                 3'b000,3'b100,3'b100,3'b000,3'b100,3'b100};
    logic       s4_wk [1:22] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,
                                 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

    tlc_actuated_ctrl #(
        .CNT_W(8), .T_GREEN(TG), .T_GREEN_MIN(TMIN), .T_YELLOW(TY),
        .T_ALLRED(TAR), .T_PED(TPED), .FLASH_HALF(FH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .en_tick           (en_tick),
        .car_ew            (car_ew),
        .ped_req           (ped_req),
        .night_mode        (night_mode),
        .light_north_south (ns),
        .light_east_west   (ew),
        .ped_walk          (walk)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_out(int ph, int el);
        case (ph)
            P_NSG:   return {3'b001, 3'b100, 1'b0};
            P_NSY:   return {3'b010, 3'b100, 1'b0};
            P_EWG:   return {3'b100, 3'b001, 1'b0};
            P_EWY:   return {3'b100, 3'b010, 1'b0};
            P_PED:   return {3'b100, 3'b100, 1'b1};
            P_FL:    return (((el / FH) % 2) == 0) ? {3'b010, 3'b100, 1'b0} : 7'b0;
            default: return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got ns=%b ew=%b walk=%b, expected ns=%b ew=%b walk=%b",
                     name, $time, act[6:4], act[3:1], act[0], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    // Reference model advanced on every clock edge from the rules of each phase
    always @(posedge clk or posedge reset) begin
        int  nph;
        bit  entering;
        if (reset) begin
            m_ph = P_AR; m_el = 0; m_dir_ns = 1'b1; m_pend = 1'b0;
        end else begin
            nph = m_ph;
            if (en_tick) begin
                case (m_ph)
                    P_NSG: if (m_el >= TMIN - 1 && (car_ew || m_pend)) nph = P_NSY;
                    P_NSY: if (m_el == TY - 1) begin nph = m_pend ? P_PED : P_AR; m_dir_ns = 1'b0; end
                    P_EWG: if (m_el == TG - 1 || (m_el >= TMIN - 1 && !car_ew)) nph = P_EWY;
                    P_EWY: if (m_el == TY - 1) begin nph = m_pend ? P_PED : P_AR; m_dir_ns = 1'b1; end
                    P_AR:  if (m_el == TAR - 1) nph = night_mode ? P_FL : (m_dir_ns ? P_NSG : P_EWG);
                    P_PED: if (m_el == TPED - 1) nph = night_mode ? P_FL : (m_dir_ns ? P_NSG : P_EWG);
                    P_FL:  if (!night_mode) begin nph = P_AR; m_dir_ns = 1'b1; end
                    default: nph = P_AR;
                endcase
            end
            entering = (nph != m_ph) && (nph == P_PED || nph == P_FL);
            m_pend = (ped_req && m_ph != P_FL) || (m_pend && !entering);
            if (en_tick) m_el = (nph != m_ph) ? 0 : m_el + 1;
            m_ph = nph;
        end
    end

    always @(negedge clk) begin
        if (!reset) check("model", {ns, ew, walk}, model_out(m_ph, m_el));
    end

    initial begin
        reset = 1'b1;
        car_ew = 1'b1;
        #22 reset = 1'b0;
        #1 check("reset_state", {ns, ew, walk}, {3'b100, 3'b100, 1'b0});

        // Constant EW demand: one full 15-tick cycle
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("cycle_car", {ns, ew, walk}, {s3_ns[k], s3_ew[k], 1'b0});
        end

        // Async reset in the middle of EW green
        repeat (6) @(negedge clk);
        check("ew_green_pre_rst", {ns, ew, walk}, {3'b100, 3'b001, 1'b0});
        #2 reset = 1'b1;
        #1 check("mid_rst", {ns, ew, walk}, {3'b100, 3'b100, 1'b0});
        car_ew = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;

        // No demand: NS green holds
        repeat (50) @(negedge clk);
        check("ns_hold", {ns, ew, walk}, {3'b001, 3'b100, 1'b0});

        // Pedestrian pulse, then night flash, ped ignored in flash, leave flash
        ped_req = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            check("ped_night", {ns, ew, walk}, {s4_ns[i], s4_ew[i], s4_wk[i]});
            ped_req = (i == 15);
            if (i == 8)  night_mode = 1'b1;
            if (i == 20) night_mode = 1'b0;
        end

        // Constant demand with a slow timebase
        car_ew = 1'b1;
        for (int c = 0; c < 400; c++) begin
            en_tick = (c % 4 == 0);
            @(negedge clk);
        end

        // EW demand dropping at chosen EW green ticks
        en_tick = 1'b1;
        for (int c = 0; c < 200; c++) begin
            car_ew = ($urandom_range(0, 5) != 0);
            @(negedge clk);
        end

        // Randomized traffic, pedestrians, night mode, timebase and resets
        for (int c = 0; c < 5000; c++) begin
            en_tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) car_ew = ~car_ew;
            ped_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) night_mode = ~night_mode;
            if ($urandom_range(0, 999) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
